wma_filter_tf: RTL



---
 rtl/wma_pkg.sv | 23 ++
 rtl/wma_tap_term.sv | 40 ++++
 rtl/wma_filter_tf.sv | 92 +++++++++
 3 files changed

// File: rtl/wma_pkg.sv
`default_nettype none
// ============================================================================
// Module      : wma_pkg
// Description : Shared limits and helpers for the power-of-two weighted
//               moving-average filter.
//               TAPS_MAX  - largest supported tap count
//               DW_MAX    - largest supported input sample width
//               wma_out_w - output width needed for a given input width
// Revision    : 1.0  initial release
// ============================================================================
package wma_pkg;

    localparam int TAPS_MAX = 8;
    localparam int DW_MAX   = 16;

    // One extra bit is enough: the sum of x * 2^-k over all k stays below 2*x,
    // so the worst case is below 2^(DW+1).
    function automatic int wma_out_w(input int dw);
        return dw + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/wma_tap_term.sv
`default_nettype none
// ============================================================================
// Module      : wma_tap_term
// Description : Combinational weighted term for one tap, x * 2^-SHIFT.
//               Truncates by default. With WMA_ROUND_EN defined, it adds half
//               an LSB before the shift (round half up). Tap 0 always passes
//               x through unchanged.
// Ports       : i_x    [DW-1:0] unsigned input sample
//               o_term [DW:0]   weighted term, zero-extended
// Macros      : WMA_ROUND_EN
// Revision    : 1.0  initial release
// ============================================================================
module wma_tap_term #(
    parameter int DW    = 8,
    parameter int SHIFT = 0
) (
    input  logic [DW-1:0] i_x,
    output logic [DW:0]   o_term
);

    logic [DW:0] w_ext;

    assign w_ext = {1'b0, i_x};

`ifdef WMA_ROUND_EN
    if (SHIFT == 0) begin : g_pass
        assign o_term = w_ext;
    end else begin : g_round
        // x < 2^DW and the half-LSB is < 2^(DW-1), so the sum fits in DW+1 bits.
        localparam logic [DW:0] c_half = (DW+1)'(1) << (SHIFT - 1);
        logic [DW:0] w_sum;
        assign w_sum  = w_ext + c_half;
        assign o_term = w_sum >> SHIFT;
    end
`else
    assign o_term = w_ext >> SHIFT;
`endif

endmodule
`default_nettype wire

// File: rtl/wma_filter_tf.sv
`default_nettype none
// ============================================================================
// Module      : wma_filter_tf
// Description : Transposed-form weighted moving-average filter. Tap k has a
//               weight of 2^-k. Each stage has a single DW+1 adder. History
//               advances only on accepted samples. Flush clears the history
//               and holds y.
// Ports       : clk        sample clock, rising edge
//               rst        asynchronous reset, active low
//               in_valid   x carries a new sample
//               x          [DW-1:0] unsigned sample
//               flush      synchronous clear of history (priority over x)
//               y          [DW:0] filtered output
//               out_valid  y updated this cycle (one pulse per sample)
//               out_primed y covers TAPS real samples since reset/flush
// Macros      : WMA_ROUND_EN (rounded tap terms; truncation when undefined)
// Revision    : 1.0  initial release
// ============================================================================
module wma_filter_tf
    import wma_pkg::*;
#(
    parameter int DW   = 8,
    parameter int TAPS = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    input  logic [DW-1:0]           x,
    input  logic                    flush,
    output logic [wma_out_w(DW)-1:0] y,
    output logic                    out_valid,
    output logic                    out_primed
);

    localparam int              c_ow   = wma_out_w(DW);
    localparam int              c_cw   = $clog2(TAPS + 1);
    localparam logic [c_cw-1:0] c_taps = c_cw'(TAPS);

    logic [c_ow-1:0] w_term   [0:TAPS-1];
    logic [c_ow-1:0] w_acc_in [1:TAPS-1];
    logic [c_ow-1:0] r_acc    [1:TAPS-1];
    logic [c_cw-1:0] r_cnt;
    logic [c_cw-1:0] w_cnt_next;

    for (genvar k = 0; k < TAPS; k++) begin : g_term
        wma_tap_term #(
            .DW    (DW),
            .SHIFT (k)
        ) u_term (
            .i_x    (x),
            .o_term (w_term[k])
        );
    end

    // Every stage adds its own term to the next-older partial sum. The oldest
    // stage has no successor and loads its term directly.
    for (genvar k = 1; k < TAPS; k++) begin : g_acc
        if (k == TAPS - 1) begin : g_last
            assign w_acc_in[k] = w_term[k];
        end else begin : g_mid
            assign w_acc_in[k] = w_term[k] + r_acc[k+1];
        end
    end

    assign w_cnt_next = (r_cnt == c_taps) ? r_cnt : r_cnt + c_cw'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int k = 1; k < TAPS; k++) r_acc[k] <= '0;
            r_cnt      <= '0;
            y          <= '0;
            out_valid  <= 1'b0;
            out_primed <= 1'b0;
        end else if (flush) begin
            // y keeps its last value. Only the history and the status are cleared.
            for (int k = 1; k < TAPS; k++) r_acc[k] <= '0;
            r_cnt      <= '0;
            out_valid  <= 1'b0;
            out_primed <= 1'b0;
        end else if (in_valid) begin
            for (int k = 1; k < TAPS; k++) r_acc[k] <= w_acc_in[k];
            r_cnt      <= w_cnt_next;
            y          <= w_term[0] + r_acc[1];
            out_valid  <= 1'b1;
            out_primed <= (w_cnt_next == c_taps);
        end else begin
            out_valid  <= 1'b0;
        end
    end

endmodule
`default_nettype wire
